// File: rtl/ram_loader_16x8.sv
// ram_loader_16x8: streams DEPTH bytes into the RAM in program mode, then optionally verifies them by checksum read-back
module ram_loader_16x8 #(
  parameter int DEPTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter bit VERIFY = 1'b1
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte,
  output logic                  o_byte_ready,
  input  logic [7:0]            i_ram_data,
  output logic                  o_program_mode,
  output logic [7:0]            o_program_data,
  output logic [ADDR_WIDTH-1:0] o_address,
  output logic                  o_write_enable,
  output logic                  o_read_enable,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_verify_error,
  output logic [7:0]            o_checksum
);
  typedef enum logic [2:0] {
    IDLE, WAIT_BYTE, WR_SETUP, WR_STROBE, WR_HOLD, RD_SETUP, RD_STROBE, DONE
  } state_t;
  state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   address_nx;
  logic [7:0]              data_nx, checksum_nx, read_sum, read_sum_nx;
  logic                    verify_error_nx, last;
  // Strobes and status decode straight from the state so they drop on the same edge as any state change
  assign o_byte_ready   = state == WAIT_BYTE;
  assign o_program_mode = state inside {WAIT_BYTE, WR_SETUP, WR_STROBE, WR_HOLD};
  assign o_write_enable = state == WR_STROBE;
  assign o_read_enable  = state == RD_STROBE;
  assign o_busy         = !(state inside {IDLE, DONE});
  assign o_done         = state == DONE;
  // Next-state and datapath updates; the address wraps to 0 naturally because DEPTH fills the address space
  always_comb begin
    state_nx        = state;
    address_nx      = o_address;
    data_nx         = o_program_data;
    checksum_nx     = o_checksum;
    read_sum_nx     = read_sum;
    verify_error_nx = o_verify_error;
    last            = o_address == ADDR_WIDTH'(DEPTH - 1);
    case (state)
      IDLE, DONE: if (i_start) begin
        state_nx        = WAIT_BYTE;
        address_nx      = '0;
        checksum_nx     = '0;
        read_sum_nx     = '0;
        verify_error_nx = 1'b0;
      end
      WAIT_BYTE: if (i_byte_valid) begin
        data_nx     = i_byte;
        checksum_nx = o_checksum + i_byte;
        state_nx    = WR_SETUP;
      end
      WR_SETUP:  state_nx = WR_STROBE;
      WR_STROBE: state_nx = WR_HOLD;
      WR_HOLD: begin
        address_nx = o_address + ADDR_WIDTH'(1);
        state_nx   = !last ? WAIT_BYTE : VERIFY ? RD_SETUP : DONE;
      end
      RD_SETUP:  state_nx = RD_STROBE;
      RD_STROBE: begin
        read_sum_nx     = read_sum + i_ram_data;
        address_nx      = o_address + ADDR_WIDTH'(1);
        state_nx        = last ? DONE : RD_SETUP;
        verify_error_nx = last ? read_sum_nx != o_checksum : o_verify_error;
      end
      default: state_nx = IDLE;
    endcase
  end
  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state          <= IDLE;
      o_address      <= '0;
      o_program_data <= '0;
      o_checksum     <= '0;
      read_sum       <= '0;
      o_verify_error <= 1'b0;
    end else begin
      state          <= state_nx;
      o_address      <= address_nx;
      o_program_data <= data_nx;
      o_checksum     <= checksum_nx;
      read_sum       <= read_sum_nx;
      o_verify_error <= verify_error_nx;
    end
  end
endmodule

// File: tb/tb_ram_loader_16x8.sv
// tb_ram_loader_16x8: directed checks of the RAM loader against a bench RAM model
module tb_ram_loader_16x8;
  logic       clk = 1'b0;
  logic       i_reset_n = 1'b0, i_start = 1'b0, i_byte_valid = 1'b0, force5 = 1'b0;
  logic [7:0] i_byte = '0;
  logic [7:0] ram_data;
  logic       o_byte_ready, o_program_mode, o_write_enable, o_read_enable, o_busy, o_done, o_verify_error;
  logic [7:0] o_program_data, o_checksum;
  logic [3:0] o_address;
  logic       r0, pm0, we0, re0, busy0, done0, verr0;
  logic [7:0] pd0, cks0;
  logic [3:0] addr0;
  logic [7:0] ram [16];
  logic [3:0] wr_addr [128];
  logic [7:0] wr_data [128];
  int         wr_cnt = 0, viol = 0, re0_cnt = 0, rdy_cycles = 0;
  int         checks = 0, errors = 0;
  logic [7:0] seq [16], ffs [16], gp [16];
  int         cyc, cyc0, base;

  always #5 clk = ~clk;

  ram_loader_16x8 #(.DEPTH(16), .ADDR_WIDTH(4), .VERIFY(1'b1)) dut (
    .i_clock(clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_byte_valid(i_byte_valid),
    .i_byte(i_byte), .o_byte_ready(o_byte_ready), .i_ram_data(ram_data),
    .o_program_mode(o_program_mode), .o_program_data(o_program_data), .o_address(o_address),
    .o_write_enable(o_write_enable), .o_read_enable(o_read_enable), .o_busy(o_busy),
    .o_done(o_done), .o_verify_error(o_verify_error), .o_checksum(o_checksum));

  ram_loader_16x8 #(.DEPTH(16), .ADDR_WIDTH(4), .VERIFY(1'b0)) dut0 (
    .i_clock(clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_byte_valid(i_byte_valid),
    .i_byte(i_byte), .o_byte_ready(r0), .i_ram_data(ram_data),
    .o_program_mode(pm0), .o_program_data(pd0), .o_address(addr0),
    .o_write_enable(we0), .o_read_enable(re0), .o_busy(busy0),
    .o_done(done0), .o_verify_error(verr0), .o_checksum(cks0));

  assign ram_data = (force5 && o_address == 4'd5) ? 8'h00 : ram[o_address];

  always @(posedge clk) begin
    if (o_write_enable) begin
      ram[o_address]          <= o_program_data;
      wr_addr[wr_cnt % 128]   <= o_address;
      wr_data[wr_cnt % 128]   <= o_program_data;
      wr_cnt                  <= wr_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (o_write_enable && o_read_enable) viol <= viol + 1;
    if (o_byte_ready && (o_write_enable || o_read_enable || !o_program_mode || !o_busy)) viol <= viol + 1;
    if (re0) re0_cnt <= re0_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_load(input logic [7:0] b [16], input bit gap, input bit poke,
                          output int c, output int c0);
    int  idx;
    bit  acc;
    base = wr_cnt;
    rdy_cycles = 0;
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    check("busy_after_start", o_busy, 1);
    check("pmode_after_start", o_program_mode, 1);
    idx = 0; c = 0; c0 = 0;
    while (!o_done && c < 400) begin
      i_byte_valid = gap ? (c % 3 == 0) : 1'b1;
      i_byte       = idx < 16 ? b[idx] : 8'h00;
      i_start      = poke && c == 10;
      acc          = i_byte_valid && o_byte_ready;
      if (o_byte_ready) rdy_cycles++;
      @(negedge clk);
      if (acc) idx++;
      c++;
      if (done0 && c0 == 0) c0 = c;
    end
    i_byte_valid = 1'b0;
    i_start      = 1'b0;
    check("done_reached", o_done, 1);
    check("bytes_accepted", idx, 16);
  endtask

  task automatic check_writes(input logic [7:0] b [16]);
    check("write_strobes", wr_cnt - base, 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("wr_addr_%0d", i), wr_addr[(base + i) % 128], i);
      check($sformatf("wr_data_%0d", i), wr_data[(base + i) % 128], b[i]);
      check($sformatf("ram_%0d", i), ram[i], b[i]);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      seq[i] = 8'(i);
      ffs[i] = 8'hFF;
      gp[i]  = 8'(17 * i + 3);
    end
    repeat (3) @(negedge clk);
    check("reset_outs", {o_byte_ready, o_program_mode, o_program_data, o_address, o_write_enable,
                         o_read_enable, o_busy, o_done, o_verify_error, o_checksum}, 0);
    check("reset_outs_v0", {r0, pm0, pd0, addr0, we0, re0, busy0, done0, verr0, cks0}, 0);
    i_reset_n = 1'b1;
    @(negedge clk);
    check("idle_not_ready", o_byte_ready, 0);

    run_load(seq, 1'b0, 1'b1, cyc, cyc0);
    check("seq_busy_cycles", cyc, 96);
    check("seq_checksum", o_checksum, 8'h78);
    check("seq_verify_error", o_verify_error, 0);
    check("seq_busy_done", o_busy, 0);
    check("seq_addr_done", o_address, 0);
    check("seq_ready_cycles", rdy_cycles, 16);
    check_writes(seq);
    check("v0_done_cycles", cyc0, 64);
    check("v0_checksum", cks0, 8'h78);
    check("v0_verify_error", verr0, 0);
    repeat (3) @(negedge clk);
    check("done_held", o_done, 1);

    run_load(ffs, 1'b0, 1'b0, cyc, cyc0);
    check("ff_busy_cycles", cyc, 96);
    check("ff_checksum", o_checksum, 8'hF0);
    check("ff_verify_error", o_verify_error, 0);
    check_writes(ffs);

    force5 = 1'b1;
    run_load(seq, 1'b0, 1'b0, cyc, cyc0);
    force5 = 1'b0;
    check("bad_checksum", o_checksum, 8'h78);
    check("bad_verify_error", o_verify_error, 1);
    check("bad_done", o_done, 1);

    run_load(gp, 1'b1, 1'b0, cyc, cyc0);
    check("gap_checksum", o_checksum, 8'h28);
    check("gap_verify_error", o_verify_error, 0);
    check_writes(gp);

    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0; i_byte_valid = 1'b1; i_byte = 8'h5A;
    cyc = 0;
    while (!(o_write_enable && o_address == 4'd7) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_strobe7", o_write_enable && o_address == 4'd7, 1);
    i_reset_n = 1'b0; i_byte_valid = 1'b0;
    @(negedge clk);
    check("abort_outs", {o_byte_ready, o_program_mode, o_program_data, o_address, o_write_enable,
                         o_read_enable, o_busy, o_done, o_verify_error, o_checksum}, 0);
    check("abort_outs_v0", {r0, pm0, pd0, addr0, we0, re0, busy0, done0, verr0, cks0}, 0);
    i_reset_n = 1'b1;
    @(negedge clk);
    run_load(seq, 1'b0, 1'b0, cyc, cyc0);
    check("reload_busy_cycles", cyc, 96);
    check("reload_checksum", o_checksum, 8'h78);
    check("reload_verify_error", o_verify_error, 0);
    check_writes(seq);

    check("strobe_rule_violations", viol, 0);
    check("v0_read_enables", re0_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_loader_16x8.md
Name: ram_loader_16x8

Overview:
- Programming initiator for the 16-byte RAM. It drives the RAM's program-mode, program-data, address, write-enable and read-enable inputs.
- Accepts a stream of DEPTH bytes over a valid/ready handshake and writes them to consecutive addresses starting at 0, using program mode.
- Optionally reads every address back over the data bus and compares an 8-bit modular checksum of what was read against what was written.
- Sits between the front-panel/serial byte source and the RAM; it owns the RAM control lines only while busy.

Parameters:
- DEPTH, 16, number of bytes per load; must equal 2**ADDR_WIDTH.
- ADDR_WIDTH, 4, width of o_address.
- VERIFY, 1, 1 = run the read-back checksum pass after the write pass; 0 = go straight to DONE.

Ports:
- i_clock  input  1  system clock; all state changes on rising edge.
- i_reset_n  input  1  synchronous, active-low reset.
- i_start  input  1  begin a load; sampled in IDLE or DONE only.
- i_byte_valid  input  1  source has a byte on i_byte.
- i_byte  input  8  byte to load.
- o_byte_ready  output  1  loader accepts i_byte this cycle.
- i_ram_data  input  8  RAM data bus as seen by the loader (read-back).
- o_program_mode  output  1  RAM program-mode select.
- o_program_data  output  8  RAM program-data input.
- o_address  output  ADDR_WIDTH  RAM address.
- o_write_enable  output  1  RAM write strobe; the RAM writes on its rising edge.
- o_read_enable  output  1  RAM read enable; the RAM drives the bus while this is high.
- o_busy  output  1  load or verify in progress.
- o_done  output  1  load complete; held until next i_start or reset.
- o_verify_error  output  1  read-back checksum mismatch; valid when o_done=1.
- o_checksum  output  8  running sum of written bytes mod 256.

Behaviour:
- Reset (i_reset_n=0 at a clock edge): state IDLE; all outputs 0, including address, data and checksum counters.
  - Reset mid-load aborts immediately; strobes drop the same edge.
  - Partially written RAM is left as is; no error is flagged.
- States: IDLE, WAIT_BYTE, WR_SETUP, WR_STROBE, WR_HOLD, RD_SETUP, RD_STROBE, DONE.
- IDLE/DONE: i_start=1 -> WAIT_BYTE.
  - Clears address, checksum, read-sum, o_done and o_verify_error.
  - Sets o_busy=1 and o_program_mode=1.
- o_program_mode is 1 from WAIT_BYTE through WR_HOLD of the last byte, and 0 in all other states.
- i_start is ignored in all other states.
- WAIT_BYTE:
  - o_byte_ready=1 (combinational on state only, not on i_byte_valid).
  - A byte is accepted on a cycle with valid&ready: it is latched into o_program_data, added to o_checksum (mod 256), and the state moves to WR_SETUP.
  - Gaps in i_byte_valid simply hold WAIT_BYTE.
- WR_SETUP: address and data stable, o_write_enable=0. Next state WR_STROBE.
- WR_STROBE: o_write_enable=1 for exactly one cycle. Next state WR_HOLD.
- WR_HOLD: o_write_enable=0, address and data still held.
  - If address = DEPTH-1: address wraps to 0; next state is RD_SETUP when VERIFY=1, else DONE.
  - Otherwise: address+1 and return to WAIT_BYTE.
- Write cost: 3 cycles per byte after acceptance; minimum load time 4*DEPTH cycles with a byte always valid.
- RD_SETUP: o_read_enable=0, address stable. Next state RD_STROBE.
- RD_STROBE: o_read_enable=1 for one cycle. At the end of the cycle, i_ram_data is added to the read-sum.
  - If address = DEPTH-1: next state DONE, and o_verify_error is set to (read-sum incl. this byte != o_checksum) on the same edge.
  - Otherwise: address+1, back to RD_SETUP.
- Read cost: 2 cycles per address.
- DONE: o_done=1, o_busy=0, o_address=0, all strobes 0, o_checksum held.
- o_write_enable and o_read_enable are never high together, and are never high outside WR_STROBE/RD_STROBE respectively.
- Mismatch granularity is per load, not per address.
- Checksum arithmetic is 8-bit wrap-around; no carry is retained.

Test Plan:
- Reset, then i_start with bytes 0x00..0x0F streamed back-to-back, VERIFY=1, bench RAM model attached -> 16 write strobes at addresses 0..15, each with matching data; o_checksum=0x78; o_done=1 with o_verify_error=0 after 64+32 cycles of busy.
- Bytes all 0xFF -> o_checksum=0xF0; read-back sums to 0xF0; no error.
- Same as the first case, but the bench forces i_ram_data=0x00 at read of address 5 (stored 0x05) -> o_verify_error=1, o_done=1.
- i_byte_valid toggling every 3rd cycle -> no byte lost or duplicated; o_byte_ready low in every non-WAIT_BYTE state; RAM contents equal the input sequence.
- Reset asserted during WR_STROBE of byte 7 -> next cycle all outputs 0 and state IDLE; a new i_start reloads from address 0.
- i_start pulsed while busy -> ignored, sequence unchanged. VERIFY=0 -> DONE after the last WR_HOLD, o_read_enable never asserted.
